ex_stage: RTL

//  EX stage of the 5-stage MIPS pipeline. Sits between ID and MEM.

---
 rtl/ex_stage_pkg.sv | 86 ++++++++
 rtl/ex_stage_div_iter.sv | 96 +++++++++
 rtl/ex_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: bus widths, field encodings,
// the ID/EX register layout, divider state codes and the ALU helper.
package ex_stage_pkg;

  localparam int STALL_BUS_WD = 6;
  localparam int ID_TO_EX_WD  = 172;
  localparam int EX_TO_MEM_WD = 147;
  localparam int EX_TO_RF_WD  = 38;

  // Pipeline stall vector bit values
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // hilo_op bit indices
  localparam int HILO_MFHI  = 0;
  localparam int HILO_MFLO  = 1;
  localparam int HILO_MTHI  = 2;
  localparam int HILO_MTLO  = 3;
  localparam int HILO_MULT  = 4;
  localparam int HILO_MULTU = 5;
  localparam int HILO_DIV   = 6;
  localparam int HILO_DIVU  = 7;

  // Store type encodings
  localparam logic [3:0] ST_SB = 4'b0001;
  localparam logic [3:0] ST_SH = 4'b0011;
  localparam logic [3:0] ST_SW = 4'b1111;

  // alu_op bit indices (one-hot)
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // Divider FSM state codes
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // ID/EX register layout, MSB first
  typedef struct packed {
    logic [7:0]  hilo_op;
    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  st_type;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  // One-hot ALU: each op result is masked by its select bit and OR-ed together
  function automatic logic [31:0] alu_calc(input logic [11:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    res = ({32{op[ALU_ADD]}}  & (a + b))
        | ({32{op[ALU_SUB]}}  & (a - b))
        | ({32{op[ALU_SLT]}}  & {31'd0, ($signed(a) < $signed(b))})
        | ({32{op[ALU_SLTU]}} & {31'd0, (a < b)})
        | ({32{op[ALU_AND]}}  & (a & b))
        | ({32{op[ALU_NOR]}}  & ~(a | b))
        | ({32{op[ALU_OR]}}   & (a | b))
        | ({32{op[ALU_XOR]}}  & (a ^ b))
        | ({32{op[ALU_SLL]}}  & (b << a[4:0]))
        | ({32{op[ALU_SRL]}}  & (b >> a[4:0]))
        | ({32{op[ALU_SRA]}}  & $unsigned($signed(b) >>> a[4:0]))
        | ({32{op[ALU_LUI]}}  & {b[15:0], 16'h0000});
    return res;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, 32 BUSY cycles,
// one DONE cycle presenting the sign-corrected quotient and remainder.
module ex_stage_div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [1:0]  state_r;
  logic [4:0]  count_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic        neg_q_r;
  logic        neg_r_r;

  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [32:0] trial_s;
  logic [33:0] diff_s;
  logic        fits_s;

  assign abs_a_s = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign abs_b_s = (is_signed && b[31]) ? (32'd0 - b) : b;
  // Shift the next dividend bit into the partial remainder and try a subtract
  assign trial_s = {rem_r, quo_r[31]};
  assign diff_s  = {1'b0, trial_s} - {2'b00, dvs_r};
  assign fits_s  = ~diff_s[33];

  // Divider state machine and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIV_IDLE;
      count_r <= 5'd0;
      rem_r   <= 32'd0;
      quo_r   <= 32'd0;
      dvs_r   <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          count_r <= 5'd0;
          if (start && (b == 32'd0)) begin
            // Divide by zero: fixed result, no iterations
            quo_r   <= 32'hFFFF_FFFF;
            rem_r   <= a;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            state_r <= DIV_DONE;
          end else if (start) begin
            quo_r   <= abs_a_s;
            rem_r   <= 32'd0;
            dvs_r   <= abs_b_s;
            neg_q_r <= is_signed & (a[31] ^ b[31]);
            neg_r_r <= is_signed & a[31];
            state_r <= DIV_BUSY;
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          rem_r   <= fits_s ? diff_s[31:0] : trial_s[31:0];
          quo_r   <= {quo_r[30:0], fits_s};
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= DIV_DONE;
          end else begin
            state_r <= DIV_BUSY;
          end
        end
        DIV_DONE: begin
          state_r <= DIV_IDLE;
        end
        default: begin
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r == DIV_BUSY);
  assign done = (state_r == DIV_DONE);
  assign quo  = neg_q_r ? (32'd0 - quo_r) : quo_r;
  assign rem  = neg_r_r ? (32'd0 - rem_r) : rem_r;

endmodule

// File: rtl/ex_stage.sv
// EX stage: ID/EX register, ALU, load/store address and byte lanes,
// HI/LO moves, single-cycle multiply and iterative divide with stall request.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  input  logic [63:0]             hilo_rdata,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_ex_t      id_ex_r;
  logic        div_served_r;
  logic        reg_update_s;

  logic [31:0] hi_s, lo_s;
  logic [31:0] src1_s, src2_s;
  logic [31:0] alu_res_s;
  logic [31:0] ex_result_s;
  logic [3:0]  ram_wen_s;
  logic [31:0] wdata_s;
  logic [65:0] hilo_bus_s;
  logic [65:0] mul_a_s, mul_b_s, prod_s;
  logic        mul_sgn_s;
  logic        div_op_s, div_start_s, div_busy_s, div_done_s;
  logic [31:0] div_quo_s, div_rem_s;

  // The register changes (bubble or load) whenever EX is not held
  assign reg_update_s = (stall[2] == NO_STOP) || (stall[3] == NO_STOP);

  // ID/EX register: reset, bubble, load or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_r <= '0;
    end else if ((stall[2] == STOP) && (stall[3] == NO_STOP)) begin
      id_ex_r <= '0;
    end else if (stall[2] == NO_STOP) begin
      id_ex_r <= id_ex_t'(id_to_ex_bus);
    end else begin
      id_ex_r <= id_ex_r;
    end
  end

  // Remembers that the held divide already produced its result, so a
  // stall from elsewhere does not restart it
  always_ff @(posedge clk) begin
    if (rst) begin
      div_served_r <= 1'b0;
    end else if (reg_update_s) begin
      div_served_r <= 1'b0;
    end else if (div_done_s) begin
      div_served_r <= 1'b1;
    end else begin
      div_served_r <= div_served_r;
    end
  end

  assign {hi_s, lo_s} = hilo_rdata;

  assign src1_s = ({32{id_ex_r.src1[0]}} & id_ex_r.rdata1)
                | ({32{id_ex_r.src1[1]}} & id_ex_r.pc)
                | ({32{id_ex_r.src1[2]}} & {27'd0, id_ex_r.inst[10:6]});
  assign src2_s = ({32{id_ex_r.src2[0]}} & id_ex_r.rdata2)
                | ({32{id_ex_r.src2[1]}} & {{16{id_ex_r.inst[15]}}, id_ex_r.inst[15:0]})
                | ({32{id_ex_r.src2[2]}} & 32'd8)
                | ({32{id_ex_r.src2[3]}} & {16'd0, id_ex_r.inst[15:0]});

  assign alu_res_s = alu_calc(id_ex_r.alu_op, src1_s, src2_s);

  assign ex_result_s = id_ex_r.hilo_op[HILO_MFHI] ? hi_s :
                       id_ex_r.hilo_op[HILO_MFLO] ? lo_s : alu_res_s;

  // Store byte lanes and lane-replicated write data
  always_comb begin
    ram_wen_s = 4'b0000;
    wdata_s   = id_ex_r.rdata2;
    if (id_ex_r.ram_en) begin
      case (id_ex_r.st_type)
        ST_SB: begin
          ram_wen_s = 4'b0001 << ex_result_s[1:0];
          wdata_s   = {4{id_ex_r.rdata2[7:0]}};
        end
        ST_SH: begin
          ram_wen_s = ex_result_s[1] ? 4'b1100 : 4'b0011;
          wdata_s   = {2{id_ex_r.rdata2[15:0]}};
        end
        ST_SW: begin
          ram_wen_s = 4'b1111;
          wdata_s   = id_ex_r.rdata2;
        end
        default: begin
          ram_wen_s = 4'b0000;
        end
      endcase
    end else begin
      ram_wen_s = 4'b0000;
    end
  end

  // Sign- or zero-extend both operands so one multiplier covers mult/multu
  assign mul_sgn_s = id_ex_r.hilo_op[HILO_MULT];
  assign mul_a_s   = {{34{mul_sgn_s & id_ex_r.rdata1[31]}}, id_ex_r.rdata1};
  assign mul_b_s   = {{34{mul_sgn_s & id_ex_r.rdata2[31]}}, id_ex_r.rdata2};
  assign prod_s    = mul_a_s * mul_b_s;

  assign div_op_s    = id_ex_r.hilo_op[HILO_DIV] | id_ex_r.hilo_op[HILO_DIVU];
  assign div_start_s = div_op_s & ~div_served_r;

  ex_stage_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .is_signed (id_ex_r.hilo_op[HILO_DIV]),
    .a         (id_ex_r.rdata1),
    .b         (id_ex_r.rdata2),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quo       (div_quo_s),
    .rem       (div_rem_s)
  );

  // HI/LO write bus: a divide writes only in its DONE cycle
  always_comb begin
    hilo_bus_s = 66'd0;
    if (div_op_s) begin
      hilo_bus_s = div_done_s ? {2'b11, div_rem_s, div_quo_s} : 66'd0;
    end else if (id_ex_r.hilo_op[HILO_MULT] || id_ex_r.hilo_op[HILO_MULTU]) begin
      hilo_bus_s = {2'b11, prod_s[63:0]};
    end else if (id_ex_r.hilo_op[HILO_MTHI]) begin
      hilo_bus_s = {2'b10, id_ex_r.rdata1, lo_s};
    end else if (id_ex_r.hilo_op[HILO_MTLO]) begin
      hilo_bus_s = {2'b01, hi_s, id_ex_r.rdata1};
    end else begin
      hilo_bus_s = 66'd0;
    end
  end

  assign stallreq_for_ex = div_start_s & ~div_done_s & (div_busy_s | 1'b1);

  assign ex_to_mem_bus = {hilo_bus_s, id_ex_r.mem_op, id_ex_r.pc, id_ex_r.ram_en,
                          ram_wen_s, id_ex_r.sel_rf_res, id_ex_r.rf_we,
                          id_ex_r.rf_waddr, ex_result_s};
  assign ex_to_rf_bus  = {id_ex_r.rf_we, id_ex_r.rf_waddr, ex_result_s};

  assign ex_is_load      = id_ex_r.ram_en & ~|ram_wen_s;
  assign data_sram_en    = id_ex_r.ram_en;
  assign data_sram_wen   = ram_wen_s;
  assign data_sram_addr  = ex_result_s;
  assign data_sram_wdata = wdata_s;

endmodule
